// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-RAM arbiter: FSM states, port ids,
// default widths and the byte-address legality check.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;

    // Illegal if not word-aligned or beyond the 2^(aw+2)-byte RAM window.
    function automatic logic addr_bad(input logic [31:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant pick (round-robin or A-first priority) with optional B lock,
// plus the last_grant register that steers round-robin ties.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter bit RR_EN     = 1'b1,
    parameter bit B_LOCK_EN = 1'b1
) (
    input  logic clock,
    input  logic resetn,
    input  logic req_a,
    input  logic req_b,
    input  logic lock,
    input  logic upd_en,
    input  logic upd_id,
    output logic gnt_vld,
    output logic gnt_id
);

    logic last_q;
    logic last_d;
    logic a_elig;

    always_comb begin
        last_d  = last_q;
        a_elig  = req_a && !(B_LOCK_EN && lock);
        gnt_vld = a_elig || req_b;
        gnt_id  = PORT_A;
        if (upd_en) begin
            last_d = upd_id;
        end
        if (a_elig && req_b) begin
            gnt_id = (RR_EN && (last_q == PORT_A)) ? PORT_B : PORT_A;
        end else if (!a_elig) begin
            gnt_id = PORT_B;
        end
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous-read data RAM between the CPU (port A)
// and the loader/debug port (B): IDLE -> ACCESS -> RESP, one access per 3 cycles.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit RR_EN     = 1'b1,
    parameter bit B_LOCK_EN = 1'b1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [31:0]       a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ack,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [31:0]       b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack,
    output logic              b_err,
    input  logic              b_lock,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic              gnt_vld;
    logic              gnt_id;
    logic              in_resp;
    logic [31:0]       sel_addr;
    logic              sel_we;
    logic              sel_err;
    logic [DATA_W-1:0] rsp_rdata;

    assign in_resp = (state_q == RESP);

    rr_arb2 #(
        .RR_EN     (RR_EN),
        .B_LOCK_EN (B_LOCK_EN)
    ) u_arb (
        .clock   (clock),
        .resetn  (resetn),
        .req_a   (a_req),
        .req_b   (b_req),
        .lock    (b_lock),
        .upd_en  (in_resp),
        .upd_id  (id_q),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        we_d        = we_q;
        err_d       = err_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        sel_addr    = (gnt_id == PORT_B) ? b_addr : a_addr;
        sel_we      = (gnt_id == PORT_B) ? b_we : a_we;
        sel_err     = addr_bad(sel_addr, ADDR_W);
        case (state_q)
            IDLE: begin
                // Latch the whole request so requesters are free once granted.
                if (gnt_vld) begin
                    state_d     = ACCESS;
                    id_d        = gnt_id;
                    we_d        = sel_we;
                    err_d       = sel_err;
                    ram_addr_d  = sel_addr[ADDR_W+1:2];
                    ram_wdata_d = (gnt_id == PORT_B) ? b_wdata : a_wdata;
                    ram_we_d    = sel_we && !sel_err;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            id_q        <= PORT_A;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            we_q        <= we_d;
            err_q       <= err_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // RESP: RAM read data is valid now; steer it to the winner only.
    assign rsp_rdata = (we_q || err_q) ? '0 : ram_rdata;
    assign a_ack     = in_resp && (id_q == PORT_A);
    assign b_ack     = in_resp && (id_q == PORT_B);
    assign a_err     = a_ack && err_q;
    assign b_err     = b_ack && err_q;
    assign a_rdata   = a_ack ? rsp_rdata : '0;
    assign b_rdata   = b_ack ? rsp_rdata : '0;

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
